pipe_stage_buf: RTL and testbench

Parametrised, generalised pipeline stage register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM and MEM/WB all instantiate it, each with its own payload width). It replaces free-running enable/flush latches with a ready/valid handshake. An optional 2-entry skid buffer gives a fully registered in_ready. Flush has defined priority, and there is a true hold path with no field cross-talk.

---
 rtl/pipe_stage_pkg.sv | 63 ++++++
 rtl/pipe_sat_cnt.sv | 27 ++
 rtl/pipe_stage_buf.sv | 159 +++++++++++++++
 tb/tb_pipe_stage_buf.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg: state encoding, occupancy constants and per-stage payload structs for pipe_stage_buf.
// Rev 1.0
`default_nettype none

package pipe_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        reg_wr;
    logic        mem_wr;
    logic        mem_rd;
    logic        mem_to_reg;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [4:0]  rd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        reg_wr;
    logic        mem_wr;
    logic        mem_rd;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [31:0] alu_out;
    logic [31:0] store_val;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_wr;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [31:0] alu_out;
    logic [31:0] load_val;
  } mem_wb_t;

  function automatic logic [1:0] occ_of(input pipe_state_t st);
    case (st)
      ONE:     occ_of = OCC_ONE;
      FULL:    occ_of = OCC_FULL;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: saturating up-counter with synchronous clear, asynchronous active-low reset.
// Rev 1.0
`default_nettype none

module pipe_sat_cnt #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: ready/valid pipeline stage register, optional 2-entry skid (SKID=1).
// Rev 1.0 -- performance counters enabled by macro PIPE_STAGE_PERF_EN.
`default_nettype none

module pipe_stage_buf
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipe_state_t       state;
  logic [DATA_W-1:0] m;
  logic              rdy;
  logic              push;
  logic              pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = m;
  assign occupancy = occ_of(state);

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] s;

      // rdy is loaded with (next state != FULL) so in_ready is a pure flop output.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          state <= EMPTY;
          m     <= '0;
          s     <= '0;
          rdy   <= 1'b0;
        end else if (flush) begin
          state <= EMPTY;
          m     <= '0;
          s     <= '0;
          rdy   <= 1'b1;
        end else begin
          case (state)
            EMPTY: begin
              rdy <= 1'b1;
              if (push) begin
                state <= ONE;
                m     <= in_data;
              end
            end
            ONE: begin
              case ({push, pop})
                2'b10: begin
                  state <= FULL;
                  s     <= in_data;
                  rdy   <= 1'b0;
                end
                2'b01: begin
                  state <= EMPTY;
                  rdy   <= 1'b1;
                end
                2'b11: begin
                  m   <= in_data;
                  rdy <= 1'b1;
                end
                default: rdy <= 1'b1;
              endcase
            end
            FULL: begin
              if (pop) begin
                state <= ONE;
                m     <= s;
                s     <= '0;
                rdy   <= 1'b1;
              end else begin
                rdy   <= 1'b0;
              end
            end
            default: begin
              state <= EMPTY;
              rdy   <= 1'b1;
            end
          endcase
        end
      end

      assign in_ready = rdy;
    end else begin : g_single
      // rdy only marks that reset has been released; readiness itself is combinational.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          state <= EMPTY;
          m     <= '0;
          rdy   <= 1'b0;
        end else if (flush) begin
          state <= EMPTY;
          m     <= '0;
          rdy   <= 1'b1;
        end else begin
          rdy <= 1'b1;
          if (push) begin
            state <= ONE;
            m     <= in_data;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
      end

      assign in_ready = rdy & (~out_valid | out_ready);
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (out_valid & ~out_ready),
    .clr  (1'b0),
    .cnt  (stall_cnt)
  );

  pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (~out_valid & out_ready),
    .clr  (1'b0),
    .cnt  (bubble_cnt)
  );

  pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (flush),
    .clr  (1'b0),
    .cnt  (flush_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scoreboard bench for pipe_stage_buf (SKID=1 with CNT_W=4, plus a SKID=0 instance).
// Rev 1.0
`default_nettype none

module tb_pipe_stage_buf;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] flush_cnt;

  logic          n_in_valid = 1'b0;
  logic          n_in_ready;
  logic [DW-1:0] n_in_data = '0;
  logic          n_out_valid;
  logic          n_out_ready = 1'b0;
  logic [DW-1:0] n_out_data;
  logic [1:0]    n_occupancy;
  logic [CW-1:0] n_stall_cnt;
  logic [CW-1:0] n_bubble_cnt;
  logic [CW-1:0] n_flush_cnt;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_flush_exp = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] held;

  always #5 CLK = ~CLK;

  pipe_stage_buf #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) u_dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
  );

  pipe_stage_buf #(.DATA_W(DW), .SKID(0), .CNT_W(CW)) u_dut_single (
    .CLK        (CLK),
    .nRST       (nRST),
    .flush      (1'b0),
    .in_valid   (n_in_valid),
    .in_ready   (n_in_ready),
    .in_data    (n_in_data),
    .out_valid  (n_out_valid),
    .out_ready  (n_out_ready),
    .out_data   (n_out_data),
    .occupancy  (n_occupancy),
    .stall_cnt  (n_stall_cnt),
    .bubble_cnt (n_bubble_cnt),
    .flush_cnt  (n_flush_cnt)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  // One clock cycle of stimulus on the SKID=1 instance; accepted payloads feed the scoreboard.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge CLK);
    if (fl) begin
      exp_q.delete();
      n_flush_exp++;
    end else if (v && in_ready) begin
      exp_q.push_back(d);
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compares every completed pop against the oldest expected payload.
  initial begin
    forever begin
      @(negedge CLK);
      if (nRST && !flush && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: actual 0x%0h required none", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    check("rst_bubble_cnt", {28'd0, bubble_cnt}, 32'd0);
    check("rst_single_in_ready", {31'd0, n_in_ready}, 32'd0);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);

    // streaming with simultaneous push/pop
    cyc(1'b1, 32'h11, 1'b1, 1'b0);
    check("stream_occ_a", {30'd0, occupancy}, 32'd1);
    cyc(1'b1, 32'h22, 1'b1, 1'b0);
    check("stream_occ_b", {30'd0, occupancy}, 32'd1);
    cyc(1'b1, 32'h33, 1'b1, 1'b0);
    check("stream_occ_c", {30'd0, occupancy}, 32'd1);
    check("stream_data_c", out_data, 32'h33);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("stream_drained", {30'd0, occupancy}, 32'd0);

    // backpressure into the skid entry
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    check("full_occ", {30'd0, occupancy}, 32'd2);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) cyc(1'b1, 32'hEE, 1'b0, 1'b0);
    check("full_hold_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_hold_data", out_data, 32'hA);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("unfull_in_ready", {31'd0, in_ready}, 32'd1);
    check("unfull_occ", {30'd0, occupancy}, 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("drained_occ", {30'd0, occupancy}, 32'd0);

    // flush while FULL, with a concurrent push attempt
    cyc(1'b1, 32'hA1, 1'b0, 1'b0);
    cyc(1'b1, 32'hB1, 1'b0, 1'b0);
    check("pre_flush_occ", {30'd0, occupancy}, 32'd2);
    cyc(1'b1, 32'hC, 1'b0, 1'b1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out_data", out_data, 32'd0);
    check("flush_occ", {30'd0, occupancy}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (16) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("post_flush_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef PIPE_STAGE_PERF_EN
    check("bubble_sat", {28'd0, bubble_cnt}, 32'hF);
`else
    check("bubble_tied", {28'd0, bubble_cnt}, 32'd0);
`endif

    // hold: every bit of M preserved while stalled
    held = 32'hA5C3_5A3C;
    cyc(1'b1, held, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("hold_data", out_data, held);
    check("hold_valid", {31'd0, out_valid}, 32'd1);
`ifdef PIPE_STAGE_PERF_EN
    check("stall_sat", {28'd0, stall_cnt}, 32'hF);
`else
    check("stall_tied", {28'd0, stall_cnt}, 32'd0);
`endif
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
`ifdef PIPE_STAGE_PERF_EN
    check("flush_cnt", {28'd0, flush_cnt}, n_flush_exp[DW-1:0]);
    check("stall_after_flush", {28'd0, stall_cnt}, 32'hF);
`else
    check("flush_cnt_tied", {28'd0, flush_cnt}, 32'd0);
`endif
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    // SKID=0: combinational in_ready
    n_in_valid  = 1'b1;
    n_in_data   = 32'h99;
    n_out_ready = 1'b0;
    @(posedge CLK);
    #1;
    n_in_valid = 1'b0;
    #1;
    check("single_valid", {31'd0, n_out_valid}, 32'd1);
    check("single_blocked", {31'd0, n_in_ready}, 32'd0);
    check("single_data", n_out_data, 32'h99);
    n_out_ready = 1'b1;
    #1;
    check("single_comb_ready", {31'd0, n_in_ready}, 32'd1);
    check("single_occ", {30'd0, n_occupancy}, 32'd1);
    @(posedge CLK);
    #1;
    check("single_drained", {31'd0, n_out_valid}, 32'd0);
    check("single_occ0", {30'd0, n_occupancy}, 32'd0);

    // reset asserted mid-transfer clears everything at once
    cyc(1'b1, 32'h77, 1'b0, 1'b0);
    cyc(1'b1, 32'h78, 1'b0, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_data", out_data, 32'd0);
    check("async_rst_occ", {30'd0, occupancy}, 32'd0);
    exp_q.delete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
